// File: rtl/alu_seg_display.sv
// alu_seg_display
//   Drives a 4-digit multiplexed seven-segment display from the ALU result bus.
//   The right three digits show the 9-bit result in decimal, with leading zeros
//   blanked. The left digit shows a letter tag. Binary-to-BCD conversion is done
//   by a shift-add-3 FSM that handles one bit per cycle. The visible digits change
//   only when a conversion completes.
// Ports
//   Clk            system clock
//   reset          asynchronous, active-high reset
//   Out_with_carry unsigned value to display (0..511)
//   Letters        tag code: A -> "A", B -> "b", C -> "C", others blank
//   seg            segments {g,f,e,d,c,b,a}, active-low, registered
//   an             digit enables, active-low one-hot, an[0] rightmost, registered
//   busy           high while a conversion is in progress, registered
module alu_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [8:0] Out_with_carry,
    input  logic [3:0] Letters,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    function automatic logic [6:0] letter_seg(input logic [3:0] c);
        logic [6:0] p;
        case (c)
            4'hA:    p = 7'h08;
            4'hB:    p = 7'h03;
            4'hC:    p = 7'h46;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    state_t      state_q, state_d;
    logic [12:0] cap_q, cap_d;          // {letter, value} being converted or last converted
    logic [3:0]  bit_q, bit_d;          // iterations already done
    logic [11:0] bcd_q, bcd_d;
    logic        busy_q, busy_d;
    logic [6:0]  units_q, units_d;      // digit registers hold ready-to-drive patterns
    logic [6:0]  tens_q, tens_d;
    logic [6:0]  hund_q, hund_d;
    logic [6:0]  letter_q, letter_d;
    logic [CW-1:0] ref_q;
    logic [1:0]  idx_q;
    logic [6:0]  seg_q;
    logic [3:0]  an_q;

    logic [12:0] live_s;
    logic [11:0] bcd_shift_s;
    logic [6:0]  digit_sel_s;

    assign live_s = {Letters, Out_with_carry};
    // Adjust nibbles first, then shift in the next result bit, MSB first.
    assign bcd_shift_s = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])} << 1
                         | {11'd0, cap_q[4'd8 - bit_q]};

    // Conversion FSM next-state and commit logic.
    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        bit_d    = bit_q;
        bcd_d    = bcd_q;
        busy_d   = busy_q;
        units_d  = units_q;
        tens_d   = tens_q;
        hund_d   = hund_q;
        letter_d = letter_q;
        case (state_q)
            IDLE: begin
                if (live_s != cap_q) begin
                    cap_d   = live_s;
                    bit_d   = 4'd0;
                    bcd_d   = 12'd0;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (live_s != cap_q) begin
                    // Input moved mid-conversion: restart on the new value.
                    cap_d = live_s;
                    bit_d = 4'd0;
                    bcd_d = 12'd0;
                end else if (bit_q == 4'd8) begin
                    units_d  = digit_seg(bcd_shift_s[3:0]);
                    tens_d   = (cap_q[8:0] < 9'd10)  ? SEG_BLANK : digit_seg(bcd_shift_s[7:4]);
                    hund_d   = (cap_q[8:0] < 9'd100) ? SEG_BLANK : digit_seg(bcd_shift_s[11:8]);
                    letter_d = letter_seg(cap_q[12:9]);
                    bcd_d    = bcd_shift_s;
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                end else begin
                    bcd_d = bcd_shift_s;
                    bit_d = bit_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Select the digit register for the current scan position.
    always_comb begin
        case (idx_q)
            2'd0:    digit_sel_s = units_q;
            2'd1:    digit_sel_s = tens_q;
            2'd2:    digit_sel_s = hund_q;
            2'd3:    digit_sel_s = letter_q;
            default: digit_sel_s = SEG_BLANK;
        endcase
    end

    // Conversion state and digit registers.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cap_q    <= 13'd0;
            bit_q    <= 4'd0;
            bcd_q    <= 12'd0;
            busy_q   <= 1'b0;
            units_q  <= 7'h40;
            tens_q   <= SEG_BLANK;
            hund_q   <= SEG_BLANK;
            letter_q <= SEG_BLANK;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            bit_q    <= bit_d;
            bcd_q    <= bcd_d;
            busy_q   <= busy_d;
            units_q  <= units_d;
            tens_q   <= tens_d;
            hund_q   <= hund_d;
            letter_q <= letter_d;
        end
    end

    // Refresh divider, scan index and registered display outputs.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            ref_q <= '0;
            idx_q <= 2'd0;
            seg_q <= SEG_BLANK;
            an_q  <= 4'hF;
        end else begin
            if (ref_q == REF_LAST) begin
                ref_q <= '0;
                idx_q <= idx_q + 2'd1;
            end else begin
                ref_q <= ref_q + {{(CW-1){1'b0}}, 1'b1};
            end
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= digit_sel_s;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule
